// File: rtl/ir_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and the memory (slave).
interface ir_fetch_unit_if #(
  parameter int unsigned PC_WIDTH = 10
);
  logic                IM_read;
  logic [PC_WIDTH-1:0] IM_address;
  logic                IM_ready;
  logic [31:0]         IM_rdata;

  modport master (
    output IM_read,
    output IM_address,
    input  IM_ready,
    input  IM_rdata
  );

  modport slave (
    input  IM_read,
    input  IM_address,
    output IM_ready,
    output IM_rdata
  );
endinterface

// File: rtl/ir_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the IM read port and holds ir/pc.
// Optional fetch timeout with sticky fetch_error is enabled by defining IFETCH_TIMEOUT_EN.
module ir_fetch_unit #(
  parameter int unsigned         PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         TIMEOUT  = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_irfetch,
  input  logic                pc_redirect,
  input  logic [PC_WIDTH-1:0] pc_target,
  ir_fetch_unit_if.master     im,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ir_valid,
  output logic                fetch_busy,
  output logic                fetch_error
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic                pend_valid_q, pend_valid_d;
  logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                error_q, error_d;

  logic [PC_WIDTH-1:0] redirect_addr;
  logic [PC_WIDTH-1:0] addr;
  logic                pend_hit;
  logic [PC_WIDTH-1:0] pend_addr;
  logic                timeout_hit;

  assign redirect_addr = {pc_target[PC_WIDTH-1:2], 2'b00};
  assign addr          = (state_q == IDLE && pc_redirect) ? redirect_addr : fetch_pc_q;
  // A redirect in the completing WAIT cycle counts as the newest pending one.
  assign pend_hit      = pend_valid_q | pc_redirect;
  assign pend_addr     = pc_redirect ? redirect_addr : pend_target_q;

  assign im.IM_address = addr;
  assign im.IM_read    = (state_q == IDLE) ? enable_irfetch : 1'b1;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign ir_valid      = ir_valid_q;
  assign fetch_busy    = (state_q == WAIT);

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign wait_cnt_d  = (state_q == WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
  assign timeout_hit = (state_q == WAIT) && !im.IM_ready && (wait_cnt_q == 8'(TIMEOUT - 1));
  assign fetch_error = error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_error = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    error_d       = error_q;

    if (state_q == IDLE) begin
      if (enable_irfetch) begin
        pend_valid_d = 1'b0;
        if (im.IM_ready) begin
          ir_d       = im.IM_rdata;
          pc_d       = addr;
          fetch_pc_d = addr + PC_WIDTH'(4);
          ir_valid_d = 1'b1;
        end else begin
          fetch_pc_d = addr;
          state_d    = WAIT;
        end
      end else if (pc_redirect) begin
        fetch_pc_d = redirect_addr;
        ir_valid_d = 1'b0;
      end
    end else begin
      if (im.IM_ready) begin
        ir_d         = im.IM_rdata;
        pc_d         = fetch_pc_q;
        state_d      = IDLE;
        pend_valid_d = 1'b0;
        if (pend_hit) begin
          fetch_pc_d = pend_addr;
          ir_valid_d = 1'b0;
        end else begin
          fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
          ir_valid_d = 1'b1;
        end
      end else if (timeout_hit) begin
        // Abort: keep ir/pc/ir_valid, but do not lose a branch seen while waiting.
        state_d      = IDLE;
        error_d      = 1'b1;
        pend_valid_d = 1'b0;
        if (pend_hit) begin
          fetch_pc_d = pend_addr;
        end
      end else if (pc_redirect) begin
        pend_valid_d  = 1'b1;
        pend_target_d = redirect_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      ir_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      error_q       <= error_d;
    end
  end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit: vector table plus hand-written corner sequences.
module tb_ir_fetch_unit;
  localparam int unsigned PW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable_irfetch = 1'b0;
  logic          pc_redirect = 1'b0;
  logic [PW-1:0] pc_target = '0;
  logic [31:0]   ir;
  logic [PW-1:0] pc;
  logic          ir_valid;
  logic          fetch_busy;
  logic          fetch_error;

  ir_fetch_unit_if #(.PC_WIDTH(PW)) im_bus ();

  ir_fetch_unit #(
    .PC_WIDTH(PW),
    .RESET_PC('0),
    .TIMEOUT (15)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_irfetch(enable_irfetch),
    .pc_redirect   (pc_redirect),
    .pc_target     (pc_target),
    .im            (im_bus),
    .ir            (ir),
    .pc            (pc),
    .ir_valid      (ir_valid),
    .fetch_busy    (fetch_busy),
    .fetch_error   (fetch_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          redir;
    logic [PW-1:0] tgt;
    int            waits;
    logic          wredir;
    logic [PW-1:0] wtgt;
    logic [31:0]   data;
    logic [PW-1:0] exp_addr;
    logic [PW-1:0] exp_pc;
    logic          exp_valid;
    logic [PW-1:0] exp_next;
  } vec_t;

  typedef struct {
    logic [31:0]   exp_ir;
    logic [PW-1:0] exp_pc;
    logic          exp_valid;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: a completed IM handshake must yield the oldest expected capture.
  logic done_q = 1'b0;
  always @(posedge clock) done_q <= reset && im_bus.IM_read && im_bus.IM_ready;

  always @(negedge clock) begin
    exp_t e;
    if (done_q) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_capture: got ir=0x%0h, expected no capture", ir);
      end else begin
        e = sb_q.pop_front();
        check("sb_ir", ir, e.exp_ir);
        check("sb_pc", 32'(pc), 32'(e.exp_pc));
        check("sb_ir_valid", 32'(ir_valid), 32'(e.exp_valid));
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clock);
    enable_irfetch   = 1'b1;
    pc_redirect      = v.redir;
    pc_target        = v.tgt;
    im_bus.IM_ready  = (v.waits == 0);
    im_bus.IM_rdata  = v.data;
    #1;
    check($sformatf("v%0d_req_addr", idx), 32'(im_bus.IM_address), 32'(v.exp_addr));
    check($sformatf("v%0d_req_read", idx), 32'(im_bus.IM_read), 32'd1);
    sb_q.push_back('{exp_ir: v.data, exp_pc: v.exp_pc, exp_valid: v.exp_valid});
    for (int i = 1; i <= v.waits; i++) begin
      @(negedge clock);
      enable_irfetch  = 1'b0;
      pc_redirect     = v.wredir && (i == 1);
      pc_target       = v.wtgt;
      im_bus.IM_ready = (i == v.waits);
      #1;
      check($sformatf("v%0d_w%0d_busy", idx, i), 32'(fetch_busy), 32'd1);
      check($sformatf("v%0d_w%0d_addr", idx, i), 32'(im_bus.IM_address), 32'(v.exp_addr));
    end
    @(negedge clock);
    enable_irfetch  = 1'b0;
    pc_redirect     = 1'b0;
    im_bus.IM_ready = 1'b0;
    #1;
    check($sformatf("v%0d_done_busy", idx), 32'(fetch_busy), 32'd0);
    check($sformatf("v%0d_next_addr", idx), 32'(im_bus.IM_address), 32'(v.exp_next));
  endtask

  initial begin
    im_bus.IM_ready = 1'b0;
    im_bus.IM_rdata = 32'd0;

    //          redir tgt      waits wredir wtgt    data           addr     pc       vld   next
    vecs[0] = '{1'b0, 10'h000, 0, 1'b0, 10'h000, 32'hAAAA_0001, 10'h000, 10'h000, 1'b1, 10'h004};
    vecs[1] = '{1'b0, 10'h000, 0, 1'b0, 10'h000, 32'hBBBB_0002, 10'h004, 10'h004, 1'b1, 10'h008};
    vecs[2] = '{1'b0, 10'h000, 0, 1'b0, 10'h000, 32'hCCCC_0003, 10'h008, 10'h008, 1'b1, 10'h00C};
    vecs[3] = '{1'b0, 10'h000, 3, 1'b0, 10'h000, 32'hDDDD_0004, 10'h00C, 10'h00C, 1'b1, 10'h010};
    vecs[4] = '{1'b1, 10'h103, 0, 1'b0, 10'h000, 32'hEEEE_0005, 10'h100, 10'h100, 1'b1, 10'h104};
    vecs[5] = '{1'b0, 10'h000, 2, 1'b1, 10'h040, 32'hFFFF_0006, 10'h104, 10'h104, 1'b0, 10'h040};
    vecs[6] = '{1'b1, 10'h3FD, 1, 1'b0, 10'h000, 32'h1234_0007, 10'h3FC, 10'h3FC, 1'b1, 10'h000};
    vecs[7] = '{1'b0, 10'h000, 0, 1'b0, 10'h000, 32'h5678_0008, 10'h000, 10'h000, 1'b1, 10'h004};
    vecs[8] = '{1'b0, 10'h000, 0, 1'b0, 10'h000, 32'h9ABC_0009, 10'h3FC, 10'h3FC, 1'b1, 10'h000};

    #1;
    check("rst_ir", ir, 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_error", 32'(fetch_error), 32'd0);
    check("rst_im_read", 32'(im_bus.IM_read), 32'd0);
    check("rst_im_addr", 32'(im_bus.IM_address), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Redirect alone in IDLE: retarget to the top word and invalidate ir.
    @(negedge clock);
    pc_redirect = 1'b1;
    pc_target   = 10'h3FE;
    #1;
    check("redir_only_comb_addr", 32'(im_bus.IM_address), 32'h3FC);
    @(negedge clock);
    pc_redirect = 1'b0;
    #1;
    check("redir_only_valid", 32'(ir_valid), 32'd0);
    check("redir_only_pc", 32'(pc), 32'h000);
    check("redir_only_addr", 32'(im_bus.IM_address), 32'h3FC);
    run_vec(8, vecs[8]);

    // Two redirects while waiting: the last one wins, enable is ignored in WAIT.
    @(negedge clock);
    enable_irfetch  = 1'b1;
    im_bus.IM_ready = 1'b0;
    im_bus.IM_rdata = 32'h0BAD_F00D;
    sb_q.push_back('{exp_ir: 32'h0BAD_F00D, exp_pc: 10'h000, exp_valid: 1'b0});
    @(negedge clock);
    pc_redirect = 1'b1;
    pc_target   = 10'h201;
    #1;
    check("lastwin_busy1", 32'(fetch_busy), 32'd1);
    @(negedge clock);
    pc_target = 10'h302;
    #1;
    check("lastwin_busy2", 32'(fetch_busy), 32'd1);
    check("lastwin_addr_held", 32'(im_bus.IM_address), 32'h000);
    @(negedge clock);
    enable_irfetch  = 1'b0;
    pc_redirect     = 1'b0;
    im_bus.IM_ready = 1'b1;
    @(negedge clock);
    im_bus.IM_ready = 1'b0;
    #1;
    check("lastwin_next_addr", 32'(im_bus.IM_address), 32'h300);
    check("lastwin_busy_done", 32'(fetch_busy), 32'd0);

    // Memory never answers.
    @(negedge clock);
    enable_irfetch  = 1'b1;
    im_bus.IM_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      enable_irfetch = 1'b0;
      #1;
      check($sformatf("stall_busy_%0d", i), 32'(fetch_busy), 32'd1);
      check($sformatf("stall_error_%0d", i), 32'(fetch_error), 32'd0);
    end
    @(negedge clock);
    #1;
`ifdef IFETCH_TIMEOUT_EN
    check("timeout_busy", 32'(fetch_busy), 32'd0);
    check("timeout_error", 32'(fetch_error), 32'd1);
    check("timeout_pc", 32'(pc), 32'h000);
    check("timeout_ir", ir, 32'h0BAD_F00D);
    check("timeout_addr", 32'(im_bus.IM_address), 32'h300);
`else
    check("no_timeout_busy", 32'(fetch_busy), 32'd1);
    check("no_timeout_error", 32'(fetch_error), 32'd0);
`endif

    // Reset in the middle of WAIT; a late IM_ready must not be captured.
    @(negedge clock);
    enable_irfetch = 1'b1;
    @(negedge clock);
    enable_irfetch = 1'b0;
    #1;
    check("midrst_busy_before", 32'(fetch_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(fetch_busy), 32'd0);
    check("midrst_ir", ir, 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_valid", 32'(ir_valid), 32'd0);
    check("midrst_error", 32'(fetch_error), 32'd0);
    check("midrst_im_read", 32'(im_bus.IM_read), 32'd0);
    check("midrst_im_addr", 32'(im_bus.IM_address), 32'd0);
    im_bus.IM_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("late_ready_ir", ir, 32'd0);
    check("late_ready_valid", 32'(ir_valid), 32'd0);
    check("late_ready_busy", 32'(fetch_busy), 32'd0);
    im_bus.IM_ready = 1'b0;

    run_vec(9, vecs[0]);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
